// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_pkg
//  Description : Shared types and constants for the sequential multiplier:
//                controller state encoding, Booth pair codes and the
//                iteration-counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_mult_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Booth radix-2 pair {q0, q(-1)}
  localparam logic [1:0] BOOTH_NOP_00 = 2'b00;
  localparam logic [1:0] BOOTH_ADD    = 2'b01;
  localparam logic [1:0] BOOTH_SUB    = 2'b10;
  localparam logic [1:0] BOOTH_NOP_11 = 2'b11;

  // Counter must hold the value N itself, hence clog2(N+1)
  function automatic int seq_mult_count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage : seq_mult_pkg
`default_nettype wire

// File: rtl/seq_mult_system_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_system_if
//  Description : Start/busy/done handshake and operand/product bus of the
//                sequential multiplier. The master drives requests, the
//                slave (the multiplier) returns result and status.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_mult_system_if #(
  parameter int DATAWIDTH_OPERAND = 8,
  parameter int DATAWIDTH_PRODUCT = 2 * DATAWIDTH_OPERAND
);
  logic                         SEQMULT_Start_InHigh;
  logic                         SEQMULT_Signed_InHigh;
  logic [DATAWIDTH_OPERAND-1:0] SEQMULT_OperandA_In;
  logic [DATAWIDTH_OPERAND-1:0] SEQMULT_OperandB_In;
  logic [DATAWIDTH_PRODUCT-1:0] SEQMULT_Product_Out;
  logic                         SEQMULT_Busy_OutHigh;
  logic                         SEQMULT_Done_OutHigh;
  logic                         SEQMULT_Zero_OutHigh;
  logic                         SEQMULT_Overflow_OutHigh;

  modport master (
    output SEQMULT_Start_InHigh, SEQMULT_Signed_InHigh,
           SEQMULT_OperandA_In, SEQMULT_OperandB_In,
    input  SEQMULT_Product_Out, SEQMULT_Busy_OutHigh, SEQMULT_Done_OutHigh,
           SEQMULT_Zero_OutHigh, SEQMULT_Overflow_OutHigh
  );

  modport slave (
    input  SEQMULT_Start_InHigh, SEQMULT_Signed_InHigh,
           SEQMULT_OperandA_In, SEQMULT_OperandB_In,
    output SEQMULT_Product_Out, SEQMULT_Busy_OutHigh, SEQMULT_Done_OutHigh,
           SEQMULT_Zero_OutHigh, SEQMULT_Overflow_OutHigh
  );
endinterface : seq_mult_system_if
`default_nettype wire

// File: rtl/seq_mult_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_datapath
//  Description : Accumulator / multiplier shift register with an (N+1)-bit
//                adder/subtractor, product register and zero/overflow flags.
//                Driven by load/step/add/sub/last strobes from the controller.
//                Macro SEQMULT_SIGNED_EN adds the Booth q(-1) bit, the
//                latched signed-mode bit and the subtract path.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_datapath #(
  parameter int DATAWIDTH_OPERAND = 8
) (
  input  wire logic                           clk_i,
  input  wire logic                           rst_i,
  input  wire logic                           load_i,
  input  wire logic                           step_i,
  input  wire logic                           add_i,
  input  wire logic                           last_i,
  input  wire logic [DATAWIDTH_OPERAND-1:0]   a_i,
  input  wire logic [DATAWIDTH_OPERAND-1:0]   b_i,
`ifdef SEQMULT_SIGNED_EN
  input  wire logic                           sub_i,
  input  wire logic                           signed_i,
  output logic                                qm1_o,
  output logic                                mode_o,
`endif
  output logic                                q0_o,
  output logic [2*DATAWIDTH_OPERAND-1:0]      product_o,
  output logic                                zero_o,
  output logic                                overflow_o
);

  localparam int OPW = DATAWIDTH_OPERAND;

  logic [OPW-1:0]   a_q;
  logic [OPW-1:0]   acc_q, acc_d;
  logic [OPW-1:0]   mult_q, mult_d;
  logic [2*OPW-1:0] product_q;
  logic             zero_q;
  logic             overflow_q;
`ifdef SEQMULT_SIGNED_EN
  logic             qm1_q;
  logic             mode_q;
`endif

  logic [OPW:0]     w_base;
  logic [OPW:0]     w_addend;
  logic [OPW:0]     w_sum;
  logic [2*OPW-1:0] w_prod;
  logic             w_zero;
  logic             w_overflow;

  // One iteration: optional add/sub into the upper half, then shift right.
  // The (N+1)-bit sum keeps the unsigned carry, or the true sign in signed
  // mode, so taking sum[N:1] is the logical/arithmetic shift respectively.
  always_comb begin
    w_base   = {1'b0, acc_q};
    w_addend = {1'b0, a_q};
`ifdef SEQMULT_SIGNED_EN
    if (mode_q) begin
      w_base   = {acc_q[OPW-1], acc_q};
      w_addend = {a_q[OPW-1], a_q};
    end
`endif
    w_sum = w_base;
    if (add_i) begin
      w_sum = w_base + w_addend;
    end
`ifdef SEQMULT_SIGNED_EN
    else if (sub_i) begin
      w_sum = w_base - w_addend;
    end
`endif
    acc_d  = w_sum[OPW:1];
    mult_d = {w_sum[0], mult_q[OPW-1:1]};
  end

  // Flags are evaluated on the final iteration's result so they land in
  // the same edge as the product.
  always_comb begin
    w_prod     = {acc_d, mult_d};
    w_zero     = (w_prod == '0);
    w_overflow = |w_prod[2*OPW-1:OPW];
`ifdef SEQMULT_SIGNED_EN
    if (mode_q) begin
      w_overflow = (w_prod[2*OPW-1:OPW] != {OPW{w_prod[OPW-1]}});
    end
`endif
  end

  // Working registers, product and flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q        <= '0;
      acc_q      <= '0;
      mult_q     <= '0;
      product_q  <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
`ifdef SEQMULT_SIGNED_EN
      qm1_q      <= 1'b0;
      mode_q     <= 1'b0;
`endif
    end else begin
      if (load_i) begin
        a_q    <= a_i;
        acc_q  <= '0;
        mult_q <= b_i;
`ifdef SEQMULT_SIGNED_EN
        qm1_q  <= 1'b0;
        mode_q <= signed_i;
`endif
      end else if (step_i) begin
        acc_q  <= acc_d;
        mult_q <= mult_d;
`ifdef SEQMULT_SIGNED_EN
        qm1_q  <= mult_q[0];
`endif
      end
      if (last_i) begin
        product_q  <= w_prod;
        zero_q     <= w_zero;
        overflow_q <= w_overflow;
      end
    end
  end

  assign q0_o       = mult_q[0];
  assign product_o  = product_q;
  assign zero_o     = zero_q;
  assign overflow_o = overflow_q;
`ifdef SEQMULT_SIGNED_EN
  assign qm1_o      = qm1_q;
  assign mode_o     = mode_q;
`endif

endmodule : seq_mult_datapath
`default_nettype wire

// File: rtl/seq_mult_system.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mult_system
//  Description : Parametrised sequential shift-and-add multiplier with a
//                start/busy/done handshake, N-bit operands, 2N-bit product
//                and zero/overflow status. Controller FSM lives here; the
//                arithmetic lives in seq_mult_datapath.
//                Macro SEQMULT_SIGNED_EN enables signed (Booth radix-2)
//                operation selected by SEQMULT_Signed_InHigh.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_mult_system
  import seq_mult_pkg::*;
#(
  parameter int DATAWIDTH_OPERAND = 8,
  parameter int DATAWIDTH_PRODUCT = 2 * DATAWIDTH_OPERAND
) (
  input  wire logic         SEQMULT_CLOCK_50,
  input  wire logic         SEQMULT_Reset_InHigh,
  seq_mult_system_if.slave  bus
);

  localparam int COUNT_W = seq_mult_count_w(DATAWIDTH_OPERAND);

  generate
    if (DATAWIDTH_PRODUCT != 2 * DATAWIDTH_OPERAND) begin : g_bad_product_width
      $error("seq_mult_system: DATAWIDTH_PRODUCT must equal 2*DATAWIDTH_OPERAND");
    end
    if (DATAWIDTH_OPERAND < 2) begin : g_bad_operand_width
      $error("seq_mult_system: DATAWIDTH_OPERAND must be at least 2");
    end
  endgenerate

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 w_load;
  logic                 w_step;
  logic                 w_add;
  logic                 w_last;
  logic                 w_q0;
`ifdef SEQMULT_SIGNED_EN
  logic                 w_sub;
  logic                 w_qm1;
  logic                 w_mode;
`else
  logic                 w_unused_signed;
  assign w_unused_signed = bus.SEQMULT_Signed_InHigh;
`endif

  // State and iteration-counter registers
  always_ff @(posedge SEQMULT_CLOCK_50 or posedge SEQMULT_Reset_InHigh) begin
    if (SEQMULT_Reset_InHigh) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and datapath strobes; the last iteration is the one that
  // sees count==1 and also captures the product.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    w_load  = 1'b0;
    w_step  = 1'b0;
    w_add   = 1'b0;
    w_last  = 1'b0;
`ifdef SEQMULT_SIGNED_EN
    w_sub   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.SEQMULT_Start_InHigh) begin
          w_load  = 1'b1;
          count_d = COUNT_W'(DATAWIDTH_OPERAND);
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        w_step  = 1'b1;
        count_d = count_q - COUNT_W'(1);
`ifdef SEQMULT_SIGNED_EN
        if (w_mode) begin
          case ({w_q0, w_qm1})
            BOOTH_ADD: w_add = 1'b1;
            BOOTH_SUB: w_sub = 1'b1;
            default:   ;
          endcase
        end else begin
          w_add = w_q0;
        end
`else
        w_add = w_q0;
`endif
        if (count_q == COUNT_W'(1)) begin
          w_last  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  seq_mult_datapath #(
    .DATAWIDTH_OPERAND (DATAWIDTH_OPERAND)
  ) u_datapath (
    .clk_i      (SEQMULT_CLOCK_50),
    .rst_i      (SEQMULT_Reset_InHigh),
    .load_i     (w_load),
    .step_i     (w_step),
    .add_i      (w_add),
    .last_i     (w_last),
    .a_i        (bus.SEQMULT_OperandA_In),
    .b_i        (bus.SEQMULT_OperandB_In),
`ifdef SEQMULT_SIGNED_EN
    .sub_i      (w_sub),
    .signed_i   (bus.SEQMULT_Signed_InHigh),
    .qm1_o      (w_qm1),
    .mode_o     (w_mode),
`endif
    .q0_o       (w_q0),
    .product_o  (bus.SEQMULT_Product_Out),
    .zero_o     (bus.SEQMULT_Zero_OutHigh),
    .overflow_o (bus.SEQMULT_Overflow_OutHigh)
  );

  assign bus.SEQMULT_Busy_OutHigh = (state_q == ST_ITER);
  assign bus.SEQMULT_Done_OutHigh = (state_q == ST_DONE);

endmodule : seq_mult_system
`default_nettype wire

// File: tb/tb_seq_mult_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_mult_system
//  Description : Self-checking bench for seq_mult_system (N=8): directed
//                cases plus random operations against an integer-arithmetic
//                reference model. Honours SEQMULT_SIGNED_EN like the design.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_mult_system;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  seq_mult_system_if #(.DATAWIDTH_OPERAND(N), .DATAWIDTH_PRODUCT(2*N)) bus ();

  seq_mult_system #(
    .DATAWIDTH_OPERAND (N),
    .DATAWIDTH_PRODUCT (2*N)
  ) dut (
    .SEQMULT_CLOCK_50     (clk),
    .SEQMULT_Reset_InHigh (rst),
    .bus                  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply, range-based overflow
  task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       output logic [2*N-1:0] prod, output logic zero, output logic ovf);
    int ia, ib, p;
    logic sm;
`ifdef SEQMULT_SIGNED_EN
    sm = s;
`else
    sm = 1'b0;
`endif
    ia = sm ? int'($signed(a)) : int'(a);
    ib = sm ? int'($signed(b)) : int'(b);
    p  = ia * ib;
    prod = p[2*N-1:0];
    zero = (p == 0);
    if (sm) ovf = (p < -(1 << (N-1))) || (p > (1 << (N-1)) - 1);
    else    ovf = (p > (1 << N) - 1);
  endtask

  // Runs one operation from IDLE; caller is at #1 after a rising edge.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input bit hold_start);
    logic [2*N-1:0] ep;
    logic ez, eo;
    int cyc;
    bit busy_ok;
    model(a, b, s, ep, ez, eo);
    bus.SEQMULT_Start_InHigh  = 1'b1;
    bus.SEQMULT_OperandA_In   = a;
    bus.SEQMULT_OperandB_In   = b;
    bus.SEQMULT_Signed_InHigh = s;
    @(posedge clk); #1;
    check("busy_rise", 32'(bus.SEQMULT_Busy_OutHigh), 32'd1);
    if (!hold_start) bus.SEQMULT_Start_InHigh = 1'b0;
    bus.SEQMULT_OperandA_In   = N'($urandom);
    bus.SEQMULT_OperandB_In   = N'($urandom);
    bus.SEQMULT_Signed_InHigh = 1'($urandom);
    cyc = 0;
    busy_ok = 1'b1;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.SEQMULT_Done_OutHigh) break;
      if (!bus.SEQMULT_Busy_OutHigh) busy_ok = 1'b0;
    end
    check("latency", 32'(cyc), 32'(N));
    check("busy_span", 32'(busy_ok), 32'd1);
    check("busy_in_done", 32'(bus.SEQMULT_Busy_OutHigh), 32'd0);
    check("product", 32'(bus.SEQMULT_Product_Out), 32'(ep));
    check("zero", 32'(bus.SEQMULT_Zero_OutHigh), 32'(ez));
    check("overflow", 32'(bus.SEQMULT_Overflow_OutHigh), 32'(eo));
    @(posedge clk); #1;
    check("done_width", 32'(bus.SEQMULT_Done_OutHigh), 32'd0);
    check("idle_busy", 32'(bus.SEQMULT_Busy_OutHigh), 32'd0);
    check("product_hold", 32'(bus.SEQMULT_Product_Out), 32'(ep));
  endtask

  initial begin
    int dones;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.SEQMULT_Start_InHigh  = 1'b0;
    bus.SEQMULT_Signed_InHigh = 1'b0;
    bus.SEQMULT_OperandA_In   = '0;
    bus.SEQMULT_OperandB_In   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    check("rst_product", 32'(bus.SEQMULT_Product_Out), 32'd0);
    check("rst_busy", 32'(bus.SEQMULT_Busy_OutHigh), 32'd0);
    check("rst_done", 32'(bus.SEQMULT_Done_OutHigh), 32'd0);
    check("rst_zero", 32'(bus.SEQMULT_Zero_OutHigh), 32'd1);
    check("rst_overflow", 32'(bus.SEQMULT_Overflow_OutHigh), 32'd0);

    // Directed cases
    do_op(8'd9,   8'd15,  1'b0, 1'b0);
    do_op(8'hFF,  8'hFF,  1'b0, 1'b0);
    do_op(8'h00,  8'hA5,  1'b0, 1'b0);
    do_op(8'hFD,  8'h05,  1'b1, 1'b0);
    do_op(8'h80,  8'h80,  1'b1, 1'b0);
    do_op(8'h80,  8'h7F,  1'b1, 1'b0);
    do_op(8'h7F,  8'hFF,  1'b1, 1'b0);

    // Start held through the operation and the DONE cycle
    do_op(8'h12,  8'h34,  1'b0, 1'b1);
    do_op(8'd7,   8'd6,   1'b0, 1'b0);

    // Reset four cycles into ITER: asynchronous clear, no Done afterwards
    bus.SEQMULT_Start_InHigh = 1'b1;
    bus.SEQMULT_OperandA_In  = 8'hC3;
    bus.SEQMULT_OperandB_In  = 8'h5A;
    @(posedge clk); #1;
    bus.SEQMULT_Start_InHigh = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy", 32'(bus.SEQMULT_Busy_OutHigh), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_product", 32'(bus.SEQMULT_Product_Out), 32'd0);
    check("arst_busy", 32'(bus.SEQMULT_Busy_OutHigh), 32'd0);
    check("arst_zero", 32'(bus.SEQMULT_Zero_OutHigh), 32'd1);
    check("arst_overflow", 32'(bus.SEQMULT_Overflow_OutHigh), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.SEQMULT_Done_OutHigh || bus.SEQMULT_Busy_OutHigh) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);
    do_op(8'd3,   8'd4,   1'b0, 1'b0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

endmodule : tb_seq_mult_system
`default_nettype wire
